command_issuer: RTL and testbench

- Host-side transmitter for the 128-bit shape command word consumed by the renderer's command parser.
- Accepts field-level draw requests over a valid/ready handshake, packs them into the 128-bit layout and buffers them in a small FIFO.
- Issues one single-cycle cmd_valid pulse per command. The parser has no backpressure, so the next command is held back until the renderer reports render_done, or until a timeout expires.

---
 rtl/command_issuer_pkg.sv | 67 ++++++
 rtl/command_issuer_fifo.sv | 66 ++++++
 rtl/command_issuer.sv | 142 ++++++++++++++
 tb/tb_command_issuer.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/command_issuer_pkg.sv
// Shared definitions for the 128-bit shape command word: field positions,
// shape ids, issuer FSM states and the packing helper.
package command_issuer_pkg;

   localparam int CMD_W = 128;

   localparam int SHAPE_MSB = 127;
   localparam int SHAPE_LSB = 124;
   localparam int X0_MSB    = 123;
   localparam int X0_LSB    = 116;
   localparam int Y0_MSB    = 115;
   localparam int Y0_LSB    = 108;
   localparam int X1_MSB    = 107;
   localparam int X1_LSB    = 100;
   localparam int Y1_MSB    = 99;
   localparam int Y1_LSB    = 92;
   localparam int X2_MSB    = 91;
   localparam int X2_LSB    = 84;
   localparam int Y2_MSB    = 83;
   localparam int Y2_LSB    = 76;
   localparam int FILL_BIT  = 75;
   localparam int COLOR_MSB = 74;
   localparam int COLOR_LSB = 51;
   localparam int BG_MSB    = 50;
   localparam int BG_LSB    = 27;
   localparam int PAD_MSB   = 26;
   localparam int PAD_LSB   = 0;

   localparam logic [3:0] SHAPE_LINE   = 4'd1;
   localparam logic [3:0] SHAPE_RECT   = 4'd2;
   localparam logic [3:0] SHAPE_CIRCLE = 4'd4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      WAIT   = 2'd2,
      GAP_ST = 2'd3
   } state_t;

   function automatic logic [CMD_W-1:0] pack_cmd(
      input logic [3:0]  shape,
      input logic [7:0]  x0,
      input logic [7:0]  y0,
      input logic [7:0]  x1,
      input logic [7:0]  y1,
      input logic [7:0]  x2,
      input logic [7:0]  y2,
      input logic        fill,
      input logic [23:0] color,
      input logic [23:0] bg
   );
      logic [CMD_W-1:0] w;
      w = '0;
      w[SHAPE_MSB:SHAPE_LSB] = shape;
      w[X0_MSB:X0_LSB]       = x0;
      w[Y0_MSB:Y0_LSB]       = y0;
      w[X1_MSB:X1_LSB]       = x1;
      w[Y1_MSB:Y1_LSB]       = y1;
      w[X2_MSB:X2_LSB]       = x2;
      w[Y2_MSB:Y2_LSB]       = y2;
      w[FILL_BIT]            = fill;
      w[COLOR_MSB:COLOR_LSB] = color;
      w[BG_MSB:BG_LSB]       = bg;
      return w;
   endfunction

endpackage

// File: rtl/command_issuer_fifo.sv
// Synchronous FIFO holding packed command words. The level counter is the
// single source of truth for full/empty; pointers simply wrap modulo DEPTH.
module cmd_fifo #(
   parameter int WIDTH = 128,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           pop_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wptr_q, wptr_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic             do_push;
   logic             do_pop;

   assign full     = (level_q == LW'(DEPTH));
   assign empty    = (level_q == '0);
   assign level    = level_q;
   assign pop_data = mem_q[rptr_q];
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;

   always_comb begin
      mem_d   = mem_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      level_d = level_q + LW'(do_push) - LW'(do_pop);
      if (do_push) begin
         mem_d[wptr_q] = push_data;
         wptr_d        = wptr_q + AW'(1);
      end
      if (do_pop) begin
         rptr_d = rptr_q + AW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
      end else begin
         mem_q   <= mem_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         level_q <= level_d;
      end
   end

endmodule

// File: rtl/command_issuer.sv
// Packs field-level draw requests into command words, queues them and
// strobes one command at a time to the parser, pacing on render_done.
module command_issuer
   import command_issuer_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 4096,
   parameter int GAP     = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [3:0]              shape_type,
   input  logic [7:0]              x0,
   input  logic [7:0]              y0,
   input  logic [7:0]              x1,
   input  logic [7:0]              y1,
   input  logic [7:0]              x2,
   input  logic [7:0]              y2,
   input  logic                    fill_enable,
   input  logic [23:0]             color,
   input  logic [23:0]             bg_color,
   input  logic                    render_done,
   output logic                    cmd_valid,
   output logic [CMD_W-1:0]        cmd_data,
   output logic                    busy,
   output logic [$clog2(DEPTH):0]  fifo_level,
   output logic                    timeout_err
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) + 1 : 1;
   localparam int GAP_W = (GAP > 1) ? $clog2(GAP) + 1 : 1;

   state_t           state_q, state_d;
   logic             cmd_valid_q, cmd_valid_d;
   logic [CMD_W-1:0] cmd_data_q, cmd_data_d;
   logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
   logic             timeout_err_q, timeout_err_d;

   logic [CMD_W-1:0] push_data;
   logic [CMD_W-1:0] fifo_head;
   logic             fifo_pop;
   logic             fifo_full;
   logic             fifo_empty;
   logic             expired;

   assign push_data = pack_cmd(shape_type, x0, y0, x1, y1, x2, y2,
                               fill_enable, color, bg_color);

   cmd_fifo #(
      .WIDTH (CMD_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (req_valid),
      .push_data (push_data),
      .pop       (fifo_pop),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (fifo_level)
   );

   // Handshake: a request transfers on any rising clk edge where req_valid
   // and req_ready are both high; req_ready depends only on the registered
   // FIFO level, so a pop never opens a slot in the same cycle.
   assign req_ready   = !fifo_full;
   assign cmd_valid   = cmd_valid_q;
   assign cmd_data    = cmd_data_q;
   assign timeout_err = timeout_err_q;
   assign busy        = (state_q != IDLE) || (fifo_level != '0);

   // The issue cycle counts as cycle 0, so the counter starts at 1 in WAIT.
   assign expired = (TIMEOUT != 0) && (state_q == WAIT) &&
                    (tmo_cnt_q >= CNT_W'(TIMEOUT - 1));

   always_comb begin
      state_d       = state_q;
      cmd_valid_d   = 1'b0;
      cmd_data_d    = cmd_data_q;
      tmo_cnt_d     = tmo_cnt_q;
      gap_cnt_d     = gap_cnt_q;
      timeout_err_d = timeout_err_q;
      fifo_pop      = 1'b0;
      case (state_q)
         // The head is popped on the edge into ISSUE so the strobe is
         // already registered while the FSM sits in ISSUE.
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop    = 1'b1;
               cmd_valid_d = 1'b1;
               cmd_data_d  = fifo_head;
               state_d     = ISSUE;
            end
         end
         ISSUE: begin
            tmo_cnt_d = CNT_W'(1);
            state_d   = WAIT;
         end
         WAIT: begin
            tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
            if (render_done || expired) begin
               if (!render_done) begin
                  timeout_err_d = 1'b1;
               end
               gap_cnt_d = '0;
               state_d   = (GAP == 0) ? IDLE : GAP_ST;
            end
         end
         GAP_ST: begin
            if (gap_cnt_q == GAP_W'(GAP - 1)) begin
               state_d = IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q + GAP_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         cmd_valid_q   <= 1'b0;
         cmd_data_q    <= '0;
         tmo_cnt_q     <= '0;
         gap_cnt_q     <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cmd_valid_q   <= cmd_valid_d;
         cmd_data_q    <= cmd_data_d;
         tmo_cnt_q     <= tmo_cnt_d;
         gap_cnt_q     <= gap_cnt_d;
         timeout_err_q <= timeout_err_d;
      end
   end

endmodule

// File: tb/tb_command_issuer.sv
// Directed bench for command_issuer: requests push expected words into a
// queue, a negedge monitor pops and compares on every cmd_valid.
module tb_command_issuer;
   import command_issuer_pkg::*;

   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 16;
   localparam int GAP     = 1;

   logic         clk;
   logic         rst;
   logic         req_valid;
   logic         req_ready;
   logic [3:0]   shape_type;
   logic [7:0]   x0, y0, x1, y1, x2, y2;
   logic         fill_enable;
   logic [23:0]  color;
   logic [23:0]  bg_color;
   logic         render_done;
   logic         cmd_valid;
   logic [127:0] cmd_data;
   logic         busy;
   logic [2:0]   fifo_level;
   logic         timeout_err;

   command_issuer #(
      .DEPTH   (DEPTH),
      .TIMEOUT (TIMEOUT),
      .GAP     (GAP)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .shape_type  (shape_type),
      .x0          (x0),
      .y0          (y0),
      .x1          (x1),
      .y1          (y1),
      .x2          (x2),
      .y2          (y2),
      .fill_enable (fill_enable),
      .color       (color),
      .bg_color    (bg_color),
      .render_done (render_done),
      .cmd_valid   (cmd_valid),
      .cmd_data    (cmd_data),
      .busy        (busy),
      .fifo_level  (fifo_level),
      .timeout_err (timeout_err)
   );

   typedef struct {
      logic [3:0]  shape;
      logic [7:0]  x0, y0, x1, y1, x2, y2;
      logic        fill;
      logic [23:0] color;
      logic [23:0] bg;
   } req_t;

   // ---------------- clock / reset / cycle counter ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // ---------------- scoreboard state ----------------
   int           total = 0;
   int           bad = 0;
   logic [127:0] exp_q[$];
   int           issue_cnt = 0;
   int           last_issue = -1;
   int           prev_issue = -1;
   logic         prev_valid = 1'b0;
   req_t         reqs[12];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   function automatic req_t mk(input logic [3:0] s, input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] c, input logic [7:0] d, input logic [7:0] e,
                               input logic [7:0] f, input logic fl, input logic [23:0] col,
                               input logic [23:0] bgc);
      req_t r;
      r.shape = s; r.x0 = a; r.y0 = b; r.x1 = c; r.y1 = d; r.x2 = e; r.y2 = f;
      r.fill = fl; r.color = col; r.bg = bgc;
      return r;
   endfunction

   // Command word layout, MSB first.
   function automatic logic [127:0] exp_word(input req_t r);
      return {r.shape, r.x0, r.y0, r.x1, r.y1, r.x2, r.y2, r.fill, r.color, r.bg, 27'h0};
   endfunction

   // ---------------- monitor ----------------
   initial forever begin
      @(negedge clk);
      if (rst) begin
         prev_valid = 1'b0;
      end else begin
         if (cmd_valid) begin
            chk_int("single_cycle_strobe", int'(prev_valid), 0);
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_cmd actual=%h required=no_command", cmd_data);
            end else begin
               chk("cmd_data", cmd_data, exp_q.pop_front());
            end
            prev_issue = last_issue;
            last_issue = cyc;
            issue_cnt++;
         end
         prev_valid = cmd_valid;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_req(input req_t r, output int acc);
      shape_type  = r.shape;
      x0 = r.x0; y0 = r.y0; x1 = r.x1; y1 = r.y1; x2 = r.x2; y2 = r.y2;
      fill_enable = r.fill;
      color       = r.color;
      bg_color    = r.bg;
      req_valid   = 1'b1;
      acc         = -1;
      for (int i = 0; i < 50; i++) begin
         if (req_ready) begin
            acc = cyc;
            exp_q.push_back(exp_word(r));
            tick();
            break;
         end
         tick();
      end
      req_valid = 1'b0;
      if (acc < 0) begin
         total++;
         bad++;
         $display("FAIL accept_wait actual=not_accepted required=accepted");
      end
   endtask

   task automatic wait_issue(input int prev, input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (issue_cnt > prev) begin
            seen = 1'b1;
            break;
         end
         tick();
      end
      if (!seen) begin
         total++;
         bad++;
         $display("FAIL %s actual=no_cmd_valid required=cmd_valid", name);
      end
   endtask

   task automatic pulse_done();
      render_done = 1'b1;
      tick();
      render_done = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- main sequence ----------------
   initial begin
      int acc, acc6, t, base, d;
      reqs[0]  = mk(SHAPE_LINE,   8'h00, 8'h00, 8'h0A, 8'h0A, 8'h00, 8'h00, 1'b0, 24'hFFFFFF, 24'h000000);
      reqs[1]  = mk(SHAPE_RECT,   8'h0A, 8'h14, 8'h64, 8'h78, 8'h00, 8'h00, 1'b1, 24'hFF0000, 24'h000080);
      reqs[2]  = mk(SHAPE_CIRCLE, 8'h40, 8'h40, 8'h20, 8'h00, 8'h00, 8'h00, 1'b1, 24'h00FF00, 24'h101010);
      reqs[3]  = mk(SHAPE_LINE,   8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 1'b0, 24'h0000FF, 24'hFFFFFF);
      reqs[4]  = mk(4'h3,         8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 1'b1, 24'h123456, 24'hABCDEF);
      reqs[5]  = mk(SHAPE_RECT,   8'h80, 8'h80, 8'hA0, 8'hA0, 8'h00, 8'h00, 1'b0, 24'hC0FFEE, 24'h000000);
      reqs[6]  = mk(SHAPE_CIRCLE, 8'h7F, 8'h7F, 8'h10, 8'h00, 8'h00, 8'h00, 1'b0, 24'hAAAAAA, 24'h555555);
      reqs[7]  = mk(SHAPE_LINE,   8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h00, 1'b1, 24'h010203, 24'h040506);
      reqs[8]  = mk(SHAPE_RECT,   8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 1'b1, 24'h800000, 24'h008000);
      reqs[9]  = mk(SHAPE_CIRCLE, 8'h20, 8'h30, 8'h05, 8'h00, 8'h00, 8'h00, 1'b0, 24'h00FFFF, 24'hFF00FF);
      reqs[10] = mk(4'hF,         8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1, 24'hFFFFFF, 24'hFFFFFF);
      reqs[11] = mk(SHAPE_LINE,   8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 1'b0, 24'hABCDEF, 24'h123456);

      rst = 1'b1; req_valid = 1'b0; render_done = 1'b0;
      shape_type = '0; x0 = '0; y0 = '0; x1 = '0; y1 = '0; x2 = '0; y2 = '0;
      fill_enable = 1'b0; color = '0; bg_color = '0;
      repeat (3) tick();
      chk_int("rst_cmd_valid", int'(cmd_valid), 0);
      chk("rst_cmd_data", cmd_data, 128'h0);
      chk_int("rst_busy", int'(busy), 0);
      chk_int("rst_fifo_level", int'(fifo_level), 0);
      chk_int("rst_timeout_err", int'(timeout_err), 0);
      chk_int("rst_req_ready", int'(req_ready), 1);
      rst = 1'b0;
      tick();

      // Single line
      base = issue_cnt;
      send_req(reqs[0], acc);
      wait_issue(base, "line_issue");
      chk_int("line_latency", last_issue, acc + 2);
      chk("line_data_literal", cmd_data, 128'h100000A0A00007FFFFF8000000000000);
      repeat (8) tick();
      chk_int("line_no_second", issue_cnt, base + 1);
      chk("line_data_held", cmd_data, 128'h100000A0A00007FFFFF8000000000000);
      chk_int("line_busy_wait", int'(busy), 1);
      pulse_done();
      repeat (3) tick();
      chk_int("line_busy_after", int'(busy), 0);

      // Stray render_done while idle and empty
      base = issue_cnt;
      pulse_done();
      repeat (5) tick();
      chk_int("stray_no_issue", issue_cnt, base);
      chk_int("stray_busy", int'(busy), 0);
      chk_int("stray_level", int'(fifo_level), 0);
      chk_int("stray_tmo", int'(timeout_err), 0);

      // Back-to-back with backpressure
      base = issue_cnt;
      send_req(reqs[1], acc);
      t = acc + 2;
      for (int i = 2; i <= 5; i++) send_req(reqs[i], d);
      chk_int("b2b_level_full", int'(fifo_level), 4);
      chk_int("b2b_ready_low", int'(req_ready), 0);
      chk_int("b2b_one_issue", issue_cnt, base + 1);
      chk_int("b2b_first_latency", last_issue, t);
      fork
         send_req(reqs[6], acc6);
         begin
            repeat (3) tick();
            chk_int("b2b_stall_ready", int'(req_ready), 0);
            chk_int("b2b_stall_level", int'(fifo_level), 4);
            d = cyc;
            pulse_done();
            wait_issue(base + 1, "b2b_second_issue");
            chk_int("b2b_done_to_issue", last_issue, d + 1 + GAP + 1);
         end
      join
      for (int i = 0; i < 4; i++) begin
         base = issue_cnt;
         pulse_done();
         wait_issue(base, "drain_issue");
         if (i == 0) chk_int("min_interval", last_issue - prev_issue, 3 + GAP);
      end
      pulse_done();
      repeat (3) tick();
      chk_int("b2b_drained_busy", int'(busy), 0);
      chk_int("b2b_drained_level", int'(fifo_level), 0);

      // Done on the expiry cycle
      base = issue_cnt;
      send_req(reqs[7], acc);
      t = acc + 2;
      wait_issue(base, "coll_issue");
      chk_int("coll_latency", last_issue, t);
      repeat (14) tick();
      chk_int("coll_cycle", cyc, t + 15);
      pulse_done();
      repeat (4) tick();
      chk_int("coll_tmo_clear", int'(timeout_err), 0);
      chk_int("coll_busy", int'(busy), 0);

      // Timeout with a second command queued
      base = issue_cnt;
      send_req(reqs[8], acc);
      t = acc + 2;
      send_req(reqs[9], d);
      wait_issue(base, "tmo_issue");
      repeat (14) tick();
      chk_int("tmo_before", int'(timeout_err), 0);
      tick();
      chk_int("tmo_rise_cycle", cyc, t + 16);
      chk_int("tmo_rise", int'(timeout_err), 1);
      wait_issue(base + 1, "tmo_next_issue");
      chk_int("tmo_next_after_gap", last_issue, t + 18);
      pulse_done();
      repeat (3) tick();
      chk_int("tmo_sticky", int'(timeout_err), 1);
      chk_int("tmo_busy", int'(busy), 0);

      // Reset while waiting with two entries queued
      base = issue_cnt;
      send_req(reqs[10], acc);
      send_req(reqs[11], d);
      send_req(reqs[0], d);
      chk_int("mid_issue_seen", issue_cnt, base + 1);
      chk_int("mid_level", int'(fifo_level), 2);
      rst = 1'b1;
      #1;
      exp_q.delete();
      chk_int("mid_rst_cmd_valid", int'(cmd_valid), 0);
      chk("mid_rst_cmd_data", cmd_data, 128'h0);
      chk_int("mid_rst_busy", int'(busy), 0);
      chk_int("mid_rst_level", int'(fifo_level), 0);
      chk_int("mid_rst_tmo", int'(timeout_err), 0);
      chk_int("mid_rst_ready", int'(req_ready), 1);
      repeat (2) tick();
      rst = 1'b0;
      base = issue_cnt;
      repeat (10) tick();
      chk_int("post_rst_no_issue", issue_cnt, base);
      chk_int("post_rst_busy", int'(busy), 0);
      send_req(reqs[3], acc);
      wait_issue(base, "post_rst_issue");
      chk_int("post_rst_latency", last_issue, acc + 2);
      pulse_done();
      repeat (3) tick();
      chk_int("post_rst_idle", int'(busy), 0);
      chk_int("exp_q_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
